// File: rtl/div_iter_unit_pkg.sv
// Shared divider definitions: FSM state encoding and the fixed stall length.
// Hazard logic uses DIV_CYCLES to know how long EXE is held for a full divide.
package div_iter_unit_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter_unit_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Purely combinational; no flow control.
module div_iter_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // The shifted remainder can exceed WIDTH bits for large unsigned divisors,
    // but the difference always fits because rem < divisor after subtraction.
    assign w_sh   = {i_rem, i_quo[WIDTH-1]};
    assign w_ge   = (w_sh >= {1'b0, i_div});
    assign w_diff = w_sh[WIDTH-1:0] - i_div;
    assign o_rem  = w_ge ? w_diff : w_sh[WIDTH-1:0];
    assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; results to the HI/LO write path.
// Latency WIDTH+1 cycles from accepted start (1 cycle for divide-by-zero).
// Holds EXE via div_busy from the start cycle; div_cancel aborts at any time.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             div_cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_busy,
    output logic             div_done,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_done;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;

    logic             w_dd_neg;
    logic             w_ds_neg;
    logic [WIDTH-1:0] w_dd_abs;
    logic [WIDTH-1:0] w_ds_abs;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo;
    logic             w_last;

    // Magnitudes stay WIDTH bits: |most-negative| is representable unsigned.
    assign w_dd_neg = div_signed & dividend[WIDTH-1];
    assign w_ds_neg = div_signed & divisor[WIDTH-1];
    assign w_dd_abs = w_dd_neg ? -dividend : dividend;
    assign w_ds_abs = w_ds_neg ? -divisor : divisor;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    div_iter_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_dvsr),
        .o_rem (w_rem),
        .o_quo (w_quo)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_done  <= 1'b0;
            r_q_out <= '0;
            r_r_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (div_cancel) begin
                r_state <= DIV_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    DIV_IDLE: begin
                        if (div_start) begin
                            if (divisor == '0) begin
                                r_q_out <= '0;
                                r_r_out <= '0;
                                r_done  <= 1'b1;
                                r_state <= DIV_DONE;
                            end else begin
                                r_quo   <= w_dd_abs;
                                r_dvsr  <= w_ds_abs;
                                r_rem   <= '0;
                                r_qneg  <= w_dd_neg ^ w_ds_neg;
                                r_rneg  <= w_dd_neg;
                                r_cnt   <= '0;
                                r_state <= DIV_CALC;
                            end
                        end
                    end
                    DIV_CALC: begin
                        r_rem <= w_rem;
                        r_quo <= w_quo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Sign-correct while entering DONE so results are valid with the pulse.
                        if (w_last) begin
                            r_q_out <= r_qneg ? -w_quo : w_quo;
                            r_r_out <= r_rneg ? -w_rem : w_rem;
                            r_done  <= 1'b1;
                            r_state <= DIV_DONE;
                        end
                    end
                    DIV_DONE: begin
                        r_cnt   <= '0;
                        r_state <= DIV_IDLE;
                    end
                    default: r_state <= DIV_IDLE;
                endcase
            end
        end
    end

    // Stall EXE combinationally in the accepting cycle.
    assign div_busy      = (r_state != DIV_IDLE) || (div_start && !div_cancel);
    assign div_done      = r_done;
    assign div_quotient  = r_q_out;
    assign div_remainder = r_r_out;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: latency, signed/unsigned results, cancel, back-to-back, reset.
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    logic        clk;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic        div_cancel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int checks = 0;
    int errors = 0;

    div_iter_unit #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_cancel    (div_cancel),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one divide at the next negedge; optionally pokes a stray start at cycle poke_at.
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                         input int poke_at, input string name);
        int lat;
        int busy_drop;
        lat = -1;
        busy_drop = 0;
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        #1;
        checks++;
        if (div_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_start got %b exp 1", name, div_busy);
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                div_start = 1'b0;
                dividend  = 32'hDEADBEEF;
                divisor   = 32'h0000_0003;
            end
            if (poke_at != 0 && n == poke_at) begin
                div_start  = 1'b1;
                div_signed = 1'b0;
                dividend   = 32'd1000;
                divisor    = 32'd3;
            end
            if (poke_at != 0 && n == poke_at + 1) div_start = 1'b0;
            if (div_done === 1'b1) begin
                lat = n;
                break;
            end
            if (div_busy !== 1'b1) busy_drop++;
        end
        div_start = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
        end
        checks++;
        if (busy_drop != 0 || div_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_hold drops %0d busy_at_done %b exp 0/1", name, busy_drop, div_busy);
        end
        checks++;
        if (div_quotient !== eq) begin
            errors++;
            $display("FAIL %s quotient got %h exp %h", name, div_quotient, eq);
        end
        checks++;
        if (div_remainder !== er) begin
            errors++;
            $display("FAIL %s remainder got %h exp %h", name, div_remainder, er);
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_cancel = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy %b done %b exp 0 0", div_busy, div_done);
        end
        checks++;
        if (div_quotient !== 32'h0 || div_remainder !== 32'h0) begin
            errors++;
            $display("FAIL reset_data q %h r %h exp 0 0", div_quotient, div_remainder);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        do_op(1'b0, 32'd100, 32'd7, DIV_CYCLES, 32'h0000000E, 32'h00000002, 0, "divu_100_7");
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL divu_after_done busy %b done %b exp 0 0", div_busy, div_done);
        end
    endtask

    task automatic test_signed();
        do_op(1'b1, 32'hFFFFFF9C, 32'd7, DIV_CYCLES, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, "div_m100_7");
        do_op(1'b1, 32'd100, 32'hFFFFFFF9, DIV_CYCLES, 32'hFFFFFFF2, 32'h00000002, 0, "div_100_m7");
        do_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, DIV_CYCLES, 32'h00000003, 32'hFFFFFFFF, 0, "div_m7_m2");
    endtask

    task automatic test_overflow();
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, DIV_CYCLES, 32'h80000000, 32'h0, 0, "div_ovf");
        do_op(1'b0, 32'hFFFFFFFF, 32'd1, DIV_CYCLES, 32'hFFFFFFFF, 32'h0, 0, "divu_max_1");
    endtask

    // Outputs before this task hold FFFFFFFF / 0 from the last overflow vector.
    task automatic test_cancel();
        int dones;
        dones = 0;
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) div_start = 1'b0;
            if (div_done === 1'b1) dones++;
        end
        div_cancel = 1'b1;
        @(negedge clk);
        div_cancel = 1'b0;
        #1;
        checks++;
        if (div_busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy got %b exp 0", div_busy);
        end
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (div_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL cancel_no_done got %0d pulses exp 0", dones);
        end
        checks++;
        if (div_quotient !== 32'hFFFFFFFF || div_remainder !== 32'h0) begin
            errors++;
            $display("FAIL cancel_hold q %h r %h exp ffffffff 0", div_quotient, div_remainder);
        end
        do_op(1'b0, 32'd9, 32'd2, DIV_CYCLES, 32'd4, 32'd1, 0, "divu_9_2_after_cancel");
    endtask

    task automatic test_back_to_back();
        do_op(1'b0, 32'd100, 32'd7, DIV_CYCLES, 32'h0000000E, 32'h2, 0, "b2b_first");
        do_op(1'b0, 32'd1234567, 32'd1000, DIV_CYCLES, 32'd1234, 32'd567, 5, "b2b_second_poked");
    endtask

    task automatic test_div_zero();
        do_op(1'b0, 32'd5, 32'd0, 1, 32'h0, 32'h0, 0, "divu_5_0");
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL divzero_after busy %b done %b exp 0 0", div_busy, div_done);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        dones = 0;
        do_op(1'b0, 32'd9, 32'd2, DIV_CYCLES, 32'd4, 32'd1, 0, "pre_reset_op");
        @(negedge clk);
        div_start = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (8) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (div_quotient !== 32'h0 || div_remainder !== 32'h0) begin
            errors++;
            $display("FAIL midreset_data q %h r %h exp 0 0", div_quotient, div_remainder);
        end
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl busy %b done %b exp 0 0", div_busy, div_done);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (div_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d pulses exp 0", dones);
        end
        do_op(1'b1, 32'hFFFFFF9C, 32'd7, DIV_CYCLES, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, "post_reset_op");
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow();
        test_cancel();
        test_back_to_back();
        test_div_zero();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions, in the EXE stage beside the ALU.
- Accepts operands from EXE on a start pulse and holds the EXE stage (busy) while iterating.
- Returns quotient/remainder for the HI/LO write path.
- Supports flush cancellation from exception/branch-flush logic.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- div_start  input  1  request; sampled only in IDLE.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- div_cancel  input  1  flush; aborts any operation in progress.
- dividend  input  WIDTH  rs operand; sampled with div_start.
- divisor  input  WIDTH  rt operand; sampled with div_start.
- div_busy  output  1  high while an accepted operation has not completed.
- div_done  output  1  one-cycle pulse; results valid in that cycle.
- div_quotient  output  WIDTH  quotient (LO); held until the next accepted start.
- div_remainder  output  WIDTH  remainder (HI); held until the next accepted start.

Behaviour:
- Reset (async, resetn=0): state=IDLE, div_busy=0, div_done=0, div_quotient=0, div_remainder=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - div_start=1, div_cancel=0, divisor!=0 in cycle T: latch |dividend|, |divisor|, the quotient-sign flag (signed and operand signs differ) and the remainder-sign flag (signed and dividend negative). Clear partial remainder; counter=0; go to CALC.
  - div_start=1 with divisor==0: go directly to DONE. Quotient=0, remainder=0. Done at T+1.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left 1. If rem_shifted >= |divisor|, subtract and set the quotient LSB.
  - Exactly WIDTH steps, cycles T+1..T+WIDTH. Counter increments per step; after step WIDTH go to DONE.
- DONE:
  - Apply sign correction: negate quotient if the quotient-sign flag is set; negate remainder if the remainder-sign flag is set. Register both to the outputs.
  - div_done=1 for this single cycle; next state IDLE.
  - Normal latency: start at T, done at T+WIDTH+1 (T+33 for WIDTH=32).
- div_busy = 1 in CALC and DONE, and combinationally 1 in IDLE when div_start=1 and div_cancel=0, so EXE stalls from cycle T.
- div_busy = 0 in the cycle after DONE.
- Unsigned magnitude path is WIDTH bits. Absolute value of 0x80000000 is the unsigned value 2^31, which needs no extra bit.
- Signed overflow case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0. No exception is raised.
- div_cancel=1 in any state: next state IDLE, div_done stays 0, outputs keep their previous values, and the partial result is discarded.
- div_cancel takes priority over a simultaneous div_start.
- div_start while in CALC/DONE is ignored; operands are not re-sampled.
- A new div_start in the first IDLE cycle after DONE is accepted (back-to-back, no bubble required).
- Operand inputs are don't-care except in the accepting cycle.
- Reset asserted mid-CALC: immediate return to reset values; no done pulse.

Decomposition:
- Shared package (CPU_Defines): div_state_t enum {DIV_IDLE, DIV_CALC, DIV_DONE}; constant DIV_CYCLES = WIDTH+1 for the stall/latency checks in hazard logic.
- Optional sub-module div_step: purely combinational, one restoring iteration (inputs rem, quo, divisor; outputs next rem, quo).
- Abs/negate helpers stay inline.

Test Plan:
- DIVU 100 / 7 at T → div_busy from T, div_done at T+33 with quotient 0x0000000E, remainder 0x00000002; busy low at T+34.
- DIV 0xFFFFFF9C (-100) / 7 → quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); DIV 100 / 0xFFFFFFF9 (-7) → quotient 0xFFFFFFF2, remainder 0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: DIVU 5 / 0 at T → div_done at T+1, quotient 0, remainder 0.
- Assert div_cancel at T+10 of a DIVU 100 / 7 → no done pulse, busy low at T+11, outputs unchanged. Then DIVU 9 / 2 is accepted and gives quotient 4, remainder 1.
- Back-to-back and reset:
  - Second start in the first IDLE cycle after done → accepted with correct result.
  - Start pulses during CALC → ignored.
  - resetn low mid-CALC → all outputs 0 asynchronously.
